gpio_input_conditioner: RTL

Conditions the raw input half of the DE-series 40-pin header (the GPIO bits a design tristates and reads) before any logic consumes them. Each bit is synchronised to the system clock and debounced; the block then produces per-bit edge pulses. A single-entry valid/ready event slot reports every change of the debounced word. It sits directly upstream of the combinational GPIO consumers (the OR/AND/XOR bank and the bit mirrors) and replaces their direct reads of the header pins.

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_debounce_bit.sv | 79 +++++++
 rtl/gpio_input_conditioner.sv | 104 ++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO input conditioner.
package gpio_pkg;

  localparam int GPIO_IN_WIDTH    = 16;
  localparam int DEBOUNCE_DEFAULT = 4;

  // One captured change of the debounced word.
  typedef struct packed {
    logic [GPIO_IN_WIDTH-1:0] data;
    logic [GPIO_IN_WIDTH-1:0] mask;
  } gpio_evt_t;

  // Debounce counter width: clog2(cycles), never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: two-flop synchroniser, debounce counter, clean level
// and one-cycle rise/fall pulses. Exposes this edge's update and next clean
// value so the parent can build events on the same edge the level changes.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic update_o,
  output logic clean_next_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1_q;
  logic          s2_q;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          update_s;

  // Next-state: count consecutive samples that disagree with the clean level.
  always_comb begin
    update_s = 1'b0;
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s2_q != clean_q) begin
      if (cnt_q == CNT_MAX) begin
        update_s = 1'b1;
        clean_d  = s2_q;
        cnt_d    = CNT_ZERO;
        rise_d   = s2_q;
        fall_d   = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // State registers: synchroniser, counter, clean level and edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= CNT_ZERO;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= pin_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o      = clean_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign update_o     = update_s;
  assign clean_next_o = clean_d;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Synchronises and debounces the GPIO header inputs, produces per-bit edge
// pulses and reports every change of the debounced word through a
// single-entry valid/ready event slot with a sticky overflow flag.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_IN_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_mask,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0] chg_s;
  logic [WIDTH-1:0] clean_next_s;
  logic             any_s;
  logic             drop_s;

  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_data_q, evt_data_d;
  logic [WIDTH-1:0] evt_mask_q, evt_mask_d;
  logic             ovf_q, ovf_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i        (CLOCK_50),
      .rst_ni       (Resetn),
      .pin_i        (gpio_in[i]),
      .clean_o      (clean[i]),
      .rise_o       (rise[i]),
      .fall_o       (fall[i]),
      .update_o     (chg_s[i]),
      .clean_next_o (clean_next_s[i])
    );
  end

  assign any_s  = |chg_s;
  assign drop_s = any_s & evt_valid_q & ~evt_ready;

  // Event slot next-state: load on change when free or draining, else drop.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    evt_mask_d  = evt_mask_q;
    if (any_s) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_data_d  = clean_next_s;
        evt_mask_d  = chg_s;
      end else begin
        evt_valid_d = evt_valid_q;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end
  end

  // Sticky overflow: a drop wins over a concurrent clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Event slot and overflow registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      evt_valid_q <= 1'b0;
      evt_data_q  <= {WIDTH{1'b0}};
      evt_mask_q  <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      evt_mask_q  <= evt_mask_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign evt_mask  = evt_mask_q;
  assign overflow  = ovf_q;

endmodule
